// File: rtl/shift_acc.sv
// shift_acc -- shift-and-accumulate unit for the multiplier datapath.
//
// Takes a stream of unsigned partial products, each tagged with a shift
// index. Every accepted beat is shifted left by in_sel*STEP bits, truncated
// to OUT_W and added into a running accumulator. A beat flagged in_last
// closes the operation; the result is then held until downstream takes it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_data, in_sel       partial product and its shift index
//   in_last               beat closes the current operation
//   out_valid/out_ready   result handshake
//   out_data              accumulated result (running sum while accumulating)
//   out_ovf               sticky overflow (truncation or carry) for this op
//   out_beats             beats accepted in this op, saturating at all-ones
//   dbg_state             current FSM state (0 = ACC, 1 = HOLD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its payload until that edge; ready may
// depend on state but never on the partner's valid.
//
// Build option: define SHIFT_ACC_SAT_EN to saturate the accumulator at
// all-ones on the first overflow event of an operation instead of wrapping.

module shift_acc #(
  parameter int IN_W   = 8,
  parameter int STEP   = 4,
  parameter int SEL_W  = 2,
  parameter int OUT_W  = 16,
  parameter int BEAT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [BEAT_W-1:0] out_beats,
  output logic              dbg_state
);

  // Full width of the largest shift, widened so there is always at least
  // one bit above OUT_W to test for truncation loss.
  localparam int SH_W  = IN_W + ((1 << SEL_W) - 1) * STEP;
  localparam int EXT_W = (SH_W > OUT_W) ? SH_W : OUT_W + 1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic               ovf_q;
  logic [BEAT_W-1:0]  beats_q;

  logic               accept;
  logic               take;
  logic [EXT_W-1:0]   sh_ext;
  logic [OUT_W-1:0]   sh;
  logic               trunc_ovf;
  logic               carry;
  logic [OUT_W-1:0]   sum;
  logic               ovf_ev;

  // Shift datapath
  always_comb begin
    sh_ext    = {{(EXT_W-IN_W){1'b0}}, in_data} << (int'(in_sel) * STEP);
    trunc_ovf = |sh_ext[EXT_W-1:OUT_W];
    sh        = sh_ext[OUT_W-1:0];
    {carry, sum} = {1'b0, acc_q} + {1'b0, sh};
    ovf_ev    = trunc_ovf | carry;
`ifdef SHIFT_ACC_SAT_EN
    // Once an operation has overflowed, the accumulator is pinned at
    // all-ones until the result is taken.
    acc_d = (ovf_ev | ovf_q) ? {OUT_W{1'b1}} : sum;
`else
    acc_d = sum;
`endif
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && in_last) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        take      = out_ready;
        if (out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      beats_q <= '0;
    end else if (take) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      beats_q <= '0;
    end else if (accept) begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_q | ovf_ev;
      if (beats_q != {BEAT_W{1'b1}}) beats_q <= beats_q + 1'b1;
    end
  end

  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign out_beats = beats_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_acc.sv
// tb_shift_acc -- self-checking bench for shift_acc.
// Driver tasks issue beats; expected results go into exp_q when an operation
// is issued; a monitor pops and compares on every result transfer.
module tb_shift_acc;
  localparam int IN_W   = 8;
  localparam int STEP   = 4;
  localparam int SEL_W  = 2;
  localparam int OUT_W  = 16;
  localparam int BEAT_W = 4;
  localparam int EXP_W  = 1 + BEAT_W + OUT_W;
  localparam longint MASK = (longint'(1) << OUT_W) - 1;
  localparam int BEAT_MAX = (1 << BEAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   in_data = '0;
  logic [SEL_W-1:0]  in_sel = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_ovf;
  logic [BEAT_W-1:0] out_beats;
  logic              dbg_state;

  shift_acc #(.IN_W(IN_W), .STEP(STEP), .SEL_W(SEL_W), .OUT_W(OUT_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .out_beats(out_beats), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 0;   // 0 random, 1 held low, 2 held high
  bit use_model = 1'b1; // push model results on last beat
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: arithmetic on wide integers
  longint m_acc;
  bit     m_ovf;
  int     m_beats;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_ovf = 1'b0; m_beats = 0;
  endtask

  task automatic model_beat(input int d, input int sel, input bit last);
    longint sh, s;
    bit ev;
    ev = 1'b0;
    sh = longint'(d) * (longint'(1) << (sel * STEP));
    if (sh > MASK) ev = 1'b1;
    sh = sh & MASK;
    s = m_acc + sh;
    if (s > MASK) ev = 1'b1;
    s = s & MASK;
`ifdef SHIFT_ACC_SAT_EN
    if (ev || m_ovf) s = MASK;
`endif
    m_ovf = m_ovf | ev;
    m_acc = s;
    if (m_beats < BEAT_MAX) m_beats++;
    if (last) begin
      if (use_model) exp_q.push_back({m_ovf, BEAT_W'(m_beats), OUT_W'(m_acc)});
      model_reset();
    end
  endtask

  task automatic push_exp(input int d, input bit ovf, input int beats);
    exp_q.push_back({ovf, BEAT_W'(beats), OUT_W'(d)});
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_beat(input int d, input int sel, input bit last);
    int t;
    in_valid = 1'b1;
    in_data  = IN_W'(d);
    in_sel   = SEL_W'(sel);
    in_last  = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL beat_accept_timeout: in_ready=%0d required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_beat(d, sel, last);
  endtask

  task automatic send_test1();
    send_beat(8'h5B, 0, 1'b0);
    send_beat(8'h23, 1, 1'b0);
    send_beat(8'h8F, 1, 1'b0);
    send_beat(8'h37, 2, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- downstream ready ----------------
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("in_ready_low_in_hold", in_ready, 0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_result: data=0x%0h ovf=%0d beats=%0d, none expected",
                   out_data, out_ovf, out_beats);
        end else begin
          check("result", {out_ovf, out_beats, out_data}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int nb;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_ovf", out_ovf, 0);
    check("reset_out_beats", out_beats, 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Directed tests use spec constants directly
    use_model = 1'b0;
    push_exp(16'h427B, 1'b0, 4);
    send_test1();
    drain();

`ifdef SHIFT_ACC_SAT_EN
    push_exp(16'hFFFF, 1'b1, 1);
`else
    push_exp(16'hF000, 1'b1, 1);
`endif
    send_beat(8'hFF, 3, 1'b1);
    drain();

`ifdef SHIFT_ACC_SAT_EN
    push_exp(16'hFFFF, 1'b1, 2);
`else
    push_exp(16'hFE00, 1'b1, 2);
`endif
    send_beat(8'hFF, 2, 1'b0);
    send_beat(8'hFF, 2, 1'b1);
    drain();

    // Stall: result held with in_valid asserted
    ready_mode = 1;
    @(posedge clk); #1;
    push_exp(16'h0120, 1'b0, 1);
    send_beat(8'h12, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'($urandom);
      in_sel   = SEL_W'($urandom);
      in_last  = 1'b1;
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 16'h0120);
      check("stall_out_beats", out_beats, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ready_mode = 2;
    drain();
    push_exp(16'h0001, 1'b0, 1);
    send_beat(8'h01, 0, 1'b1);
    drain();
    ready_mode = 0;

    // Asynchronous reset mid-operation
    send_beat(8'h5B, 0, 1'b0);
    send_beat(8'h23, 1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_beats", out_beats, 0);
    check("async_rst_out_ovf", out_ovf, 0);
    check("async_rst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    push_exp(16'h427B, 1'b0, 4);
    send_test1();
    drain();

    // Beat counter saturation
    push_exp(16'h0000, 1'b0, 15);
    for (int i = 0; i < 17; i++) send_beat(0, 0, 1'b0);
    send_beat(0, 0, 1'b1);
    drain();

    // Randomized operations against the model
    use_model = 1'b1;
    model_reset();
    for (int op = 0; op < 40; op++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_data = IN_W'($urandom);
          in_sel  = SEL_W'($urandom);
          in_last = 1'($urandom);
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        send_beat(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), b == nb - 1);
      end
    end
    ready_mode = 2;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
